// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/reset sequencer for the stopwatch counter chain.
// Generates the count square wave, the clear pulse and the display-freeze flag.
module stopwatch_ctrl #(
    parameter int HALF_PERIOD = 250000,
    parameter int CLR_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lr,
    output logic       tick_o,
    output logic       clr_o,
    output logic       hold_o,
    output logic       run_o,
    output logic [1:0] state_o
);
    localparam int DW = $clog2(HALF_PERIOD);
    localparam int CW = CLR_LEN > 1 ? $clog2(CLR_LEN) : 1;

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;

    state_t        state, nxt;
    logic [2:0]    ss_sh, lr_sh;
    logic          ss_e, lr_e, ss, lr, clr_req;
    logic [DW-1:0] div;
    logic [CW-1:0] ccnt;

    assign state_o = state;
    // ss beats lr when both arrive together; nothing acts while a clear is in progress
    assign ss = ss_e & ~clr_o;
    assign lr = lr_e & ~clr_o & ~ss_e;

    always_comb begin
        nxt     = state;
        clr_req = 1'b0;
        case (state)
            IDLE:    begin nxt = ss ? RUN : IDLE;                 clr_req = lr; end
            RUN:     nxt = ss ? PAUSE : lr ? LAP : RUN;
            LAP:     nxt = ss ? PAUSE : lr ? RUN : LAP;
            default: begin nxt = ss ? RUN : lr ? IDLE : PAUSE;    clr_req = lr; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_sh  <= '0;
            lr_sh  <= '0;
            ss_e   <= 1'b0;
            lr_e   <= 1'b0;
            state  <= IDLE;
            hold_o <= 1'b0;
            run_o  <= 1'b0;
        end else begin
            ss_sh  <= {ss_sh[1:0], btn_ss};
            lr_sh  <= {lr_sh[1:0], btn_lr};
            ss_e   <= ss_sh[1] & ~ss_sh[2];
            lr_e   <= lr_sh[1] & ~lr_sh[2];
            state  <= nxt;
            hold_o <= nxt == LAP;
            run_o  <= nxt == RUN || nxt == LAP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_o <= 1'b0;
            ccnt  <= '0;
        end else begin
            clr_o <= clr_req | (clr_o & (ccnt != '0));
            ccnt  <= clr_req ? CW'(CLR_LEN - 1) : (ccnt != '0) ? ccnt - 1'b1 : ccnt;
        end
    end

    // a clear zeroes the tick in the same cycle so the counter never sees a stray fall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div    <= '0;
            tick_o <= 1'b0;
        end else if (clr_req || state == IDLE) begin
            div    <= '0;
            tick_o <= 1'b0;
        end else if (state == RUN || state == LAP) begin
            div    <= (div == DW'(HALF_PERIOD - 1)) ? '0 : div + 1'b1;
            tick_o <= tick_o ^ (div == DW'(HALF_PERIOD - 1));
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench; expected outputs come from an abstract
// model that counts running cycles and derives tick and counter value from them.
module tb_stopwatch_ctrl;
    localparam int HP = 4;
    localparam int CL = 2;

    logic       clk = 1'b0, rst = 1'b1, btn_ss = 1'b0, btn_lr = 1'b0;
    logic       tick_o, clr_o, hold_o, run_o;
    logic [1:0] state_o;

    stopwatch_ctrl #(.HALF_PERIOD(HP), .CLR_LEN(CL)) dut (
        .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lr(btn_lr),
        .tick_o(tick_o), .clr_o(clr_o), .hold_o(hold_o), .run_o(run_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    logic [21:0] sb[$];
    int          total = 0, passed = 0;
    logic [4:0]  hs, hl;
    int          st, rc, cl;
    int          nss[4] = '{1, 2, 1, 2};
    int          nlr[4] = '{0, 3, 0, 1};
    logic [15:0] qd;
    logic        tprev;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    task automatic model_reset();
        hs = '0; hl = '0; st = 0; rc = 0; cl = 0;
    endtask

    // one clock edge: model the edge using the levels present at it, then drive new levels
    task automatic step(input logic s, input logic l);
        logic a_ss, a_lr, busy, ss, lr, do_clr;
        @(posedge clk);
        hs = {hs[3:0], btn_ss};
        hl = {hl[3:0], btn_lr};
        a_ss = hs[3] & ~hs[4];
        a_lr = hl[3] & ~hl[4];
        busy = cl > 0;
        ss = a_ss && !busy;
        lr = a_lr && !busy && !a_ss;
        do_clr = lr && (st == 0 || st == 2);
        rc = (do_clr || st == 0) ? 0 : (st == 1 || st == 3) ? rc + 1 : rc;
        st = ss ? nss[st] : lr ? nlr[st] : st;
        cl = do_clr ? CL : busy ? cl - 1 : 0;
        sb.push_back({2'(st), ((rc / HP) % 2) == 1, cl > 0, st == 3, st == 1 || st == 3, 16'(rc / (2 * HP))});
        #1;
        btn_ss = s;
        btn_lr = l;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic press(input logic s, input logic l);
        step(s, l);
        step(1'b0, 1'b0);
    endtask

    task automatic do_reset(input string n);
        @(negedge clk);
        #1 rst = 1'b0;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        #1 chk(n, {state_o, tick_o, clr_o, hold_o, run_o}, 0);
        model_reset();
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            qd = '0;
            tprev = 1'b0;
        end else begin
            if (clr_o) qd = '0;
            else if (tprev && !tick_o) qd++;
            tprev = tick_o;
            if (sb.size() > 0)
                chk($sformatf("outputs@%0t", $time), {state_o, tick_o, clr_o, hold_o, run_o, qd}, sb.pop_front());
        end
    end

    initial begin
        int n;
        model_reset();
        #2 rst = 1'b0;
        #1 chk("reset_outputs", {state_o, tick_o, clr_o, hold_o, run_o}, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        idle(50);
        press(1'b1, 1'b0);
        idle(44);
        press(1'b1, 1'b0);
        idle(20);
        press(1'b1, 1'b0);
        idle(20);
        press(1'b0, 1'b1);
        idle(12);
        press(1'b0, 1'b1);
        idle(12);
        do_reset("reset_before_pause");
        press(1'b1, 1'b0);
        idle(3);
        press(1'b1, 1'b0);
        idle(20);
        press(1'b0, 1'b1);
        idle(10);
        press(1'b1, 1'b0);
        idle(6);
        press(1'b0, 1'b1);
        idle(6);
        press(1'b1, 1'b1);
        idle(8);
        press(1'b1, 1'b0);
        idle(6);
        press(1'b1, 1'b1);
        idle(8);
        repeat (1500) step($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
        idle(8);
        do_reset("reset_before_clear");
        press(1'b0, 1'b1);
        n = 0;
        while (cl == 0 && n < 10) begin
            step(1'b0, 1'b0);
            n++;
        end
        @(negedge clk);
        #1 chk("clr_before_rst", 32'(clr_o), 1);
        rst = 1'b0;
        #1 chk("async_rst_mid_clear", {state_o, tick_o, clr_o, hold_o, run_o}, 0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
